// File: rtl/evm_pkg.sv
// Shared types and constants for the EVM booth scheduler.
// Holds the scheduler state encoding and the 2-bit candidate vote codes.
package evm_pkg;

    localparam int STATE_W = 3;
    localparam int VOTE_W  = 2;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE      = 3'd0,
        S_ARB       = 3'd1,
        S_WAIT_VOTE = 3'd2,
        S_READY     = 3'd3,
        S_CAST      = 3'd4,
        S_SETTLE    = 3'd5,
        S_CLOSE     = 3'd6,
        S_DONE      = 3'd7
    } sched_state_e;

    localparam logic [VOTE_W-1:0] VOTE_NONE = 2'b00;
    localparam logic [VOTE_W-1:0] VOTE_C1   = 2'b01;
    localparam logic [VOTE_W-1:0] VOTE_C2   = 2'b10;
    localparam logic [VOTE_W-1:0] VOTE_C3   = 2'b11;

endpackage

// File: rtl/evm_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after i_ptr, wrapping.
// Produces a one-hot grant plus its index; the pointer register lives in the caller.
module evm_rr_arbiter
    import evm_pkg::*;
#(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N-1:0]     o_grant,
    output logic [PTR_W-1:0] o_idx,
    output logic             o_any
);

    always_comb begin : p_pick
        int w_pos;
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_pos   = 0;
        for (int k = 0; k < N; k++) begin
            w_pos = (int'(i_ptr) + k) % N;
            if (!o_any && i_req[w_pos[PTR_W-1:0]]) begin
                o_grant[w_pos[PTR_W-1:0]] = 1'b1;
                o_idx                     = w_pos[PTR_W-1:0];
                o_any                     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/evm_booth_scheduler.sv
// Shares one evm vote-counting core among NUM_BOOTHS booths via round-robin grants.
// Optional macro EVM_SCHED_TIMEOUT_EN adds a per-grant vote timeout.
module evm_booth_scheduler
    import evm_pkg::*;
#(
    parameter int NUM_BOOTHS     = 4,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    switch_on_evm,
    input  logic                    close_req,
    input  logic [NUM_BOOTHS-1:0]   booth_req,
    input  logic [NUM_BOOTHS-1:0]   booth_vote_valid,
    input  logic [2*NUM_BOOTHS-1:0] booth_vote,
    output logic [NUM_BOOTHS-1:0]   booth_grant,
    output logic [NUM_BOOTHS-1:0]   booth_ack,
    output logic [NUM_BOOTHS-1:0]   booth_reject,
    output logic                    candidate_ready,
    output logic                    vote_candidate_1,
    output logic                    vote_candidate_2,
    output logic                    vote_candidate_3,
    output logic                    voting_session_done,
    output logic [CNT_W-1:0]        voters_served,
    output logic                    sched_busy,
    output logic [STATE_W-1:0]      dbg_state
);

    localparam int PTR_W = $clog2(NUM_BOOTHS);

    sched_state_e            r_state;
    logic [PTR_W-1:0]        r_ptr;
    logic [PTR_W-1:0]        r_gidx;
    logic [NUM_BOOTHS-1:0]   r_grant;
    logic [VOTE_W-1:0]       r_code;
    logic [NUM_BOOTHS-1:0]   r_reject;
    logic [CNT_W-1:0]        r_voters;

    logic [NUM_BOOTHS-1:0]   w_arb_grant;
    logic [PTR_W-1:0]        w_arb_idx;
    logic                    w_arb_any;
    logic                    w_valid;
    logic [VOTE_W-1:0]       w_code;
    logic [PTR_W-1:0]        w_next_ptr;
    logic                    w_saturated;

`ifdef EVM_SCHED_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES);
    logic [TO_W-1:0]         r_to_cnt;
`endif

    evm_rr_arbiter #(.N(NUM_BOOTHS), .PTR_W(PTR_W)) u_arb (
        .i_req   (booth_req),
        .i_ptr   (r_ptr),
        .o_grant (w_arb_grant),
        .o_idx   (w_arb_idx),
        .o_any   (w_arb_any)
    );

    // Only the granted booth's valid bit and code are ever looked at.
    assign w_valid     = booth_vote_valid[r_gidx];
    assign w_code      = booth_vote[{r_gidx, 1'b0} +: VOTE_W];
    assign w_next_ptr  = (r_gidx == PTR_W'(NUM_BOOTHS - 1)) ? '0 : r_gidx + 1'b1;
    assign w_saturated = (r_voters == '1);

    always_ff @(posedge clk) begin
        if (!rst || !switch_on_evm) begin
            r_state  <= S_IDLE;
            r_ptr    <= '0;
            r_gidx   <= '0;
            r_grant  <= '0;
            r_code   <= VOTE_NONE;
            r_reject <= '0;
            r_voters <= '0;
`ifdef EVM_SCHED_TIMEOUT_EN
            r_to_cnt <= '0;
`endif
        end else begin
            r_reject <= '0;
            case (r_state)
                S_IDLE: r_state <= S_ARB;
                S_ARB: begin
                    if (close_req) begin
                        r_state <= S_CLOSE;
                    end else if (!w_saturated && w_arb_any) begin
                        r_grant  <= w_arb_grant;
                        r_gidx   <= w_arb_idx;
                        r_state  <= S_WAIT_VOTE;
`ifdef EVM_SCHED_TIMEOUT_EN
                        r_to_cnt <= '0;
`endif
                    end
                end
                S_WAIT_VOTE: begin
                    if (w_valid) begin
                        if (w_code == VOTE_NONE) begin
                            r_reject <= r_grant;
                            r_ptr    <= w_next_ptr;
                            r_state  <= S_ARB;
                        end else begin
                            r_code  <= w_code;
                            r_state <= S_READY;
                        end
                    end
`ifdef EVM_SCHED_TIMEOUT_EN
                    else if (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        r_reject <= r_grant;
                        r_ptr    <= w_next_ptr;
                        r_state  <= S_ARB;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
`endif
                end
                S_READY:  r_state <= S_CAST;
                S_CAST:   r_state <= S_SETTLE;
                S_SETTLE: begin
                    r_voters <= r_voters + 1'b1;
                    r_ptr    <= w_next_ptr;
                    r_state  <= S_ARB;
                end
                S_CLOSE:  r_state <= S_DONE;
                S_DONE:   r_state <= S_DONE;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    // Core-facing strobes are pure state decodes, so ready and vote never overlap.
    assign booth_grant         = (r_state == S_WAIT_VOTE) ? r_grant : '0;
    assign booth_ack           = (r_state == S_SETTLE) ? r_grant : '0;
    assign booth_reject        = r_reject;
    assign candidate_ready     = (r_state == S_READY);
    assign vote_candidate_1    = (r_state == S_CAST) && (r_code == VOTE_C1);
    assign vote_candidate_2    = (r_state == S_CAST) && (r_code == VOTE_C2);
    assign vote_candidate_3    = (r_state == S_CAST) && (r_code == VOTE_C3);
    assign voting_session_done = (r_state == S_CLOSE);
    assign voters_served       = r_voters;
    assign sched_busy          = (r_state != S_IDLE) && (r_state != S_ARB) && (r_state != S_DONE);
    assign dbg_state           = r_state;

endmodule

// File: tb/tb_evm_booth_scheduler.sv
// Directed bench for evm_booth_scheduler with a vote-code scoreboard and a tiny core tally.
module tb_evm_booth_scheduler;
    import evm_pkg::*;

    localparam int NB = 4;
    localparam int CW = 7;

    logic            clk = 1'b0;
    logic            rst;
    logic            switch_on_evm;
    logic            close_req;
    logic [NB-1:0]   booth_req;
    logic [NB-1:0]   booth_vote_valid;
    logic [2*NB-1:0] booth_vote;
    logic [NB-1:0]   booth_grant;
    logic [NB-1:0]   booth_ack;
    logic [NB-1:0]   booth_reject;
    logic            candidate_ready;
    logic            vote_candidate_1;
    logic            vote_candidate_2;
    logic            vote_candidate_3;
    logic            voting_session_done;
    logic [CW-1:0]   voters_served;
    logic            sched_busy;
    logic [STATE_W-1:0] dbg_state;

    always #5 clk = ~clk;

    evm_booth_scheduler #(.NUM_BOOTHS(NB), .TIMEOUT_CYCLES(64), .CNT_W(CW)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .switch_on_evm       (switch_on_evm),
        .close_req           (close_req),
        .booth_req           (booth_req),
        .booth_vote_valid    (booth_vote_valid),
        .booth_vote          (booth_vote),
        .booth_grant         (booth_grant),
        .booth_ack           (booth_ack),
        .booth_reject        (booth_reject),
        .candidate_ready     (candidate_ready),
        .vote_candidate_1    (vote_candidate_1),
        .vote_candidate_2    (vote_candidate_2),
        .vote_candidate_3    (vote_candidate_3),
        .voting_session_done (voting_session_done),
        .voters_served       (voters_served),
        .sched_busy          (sched_busy),
        .dbg_state           (dbg_state)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [1:0] exp_q[$];
    int exp_ptr = 0;
    int exp_voters = 0;
    int core_c1 = 0, core_c2 = 0, core_c3 = 0;
    bit core_done = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [31:0] outs_vec();
        return {14'd0, booth_grant, booth_ack, booth_reject, candidate_ready,
                vote_candidate_1, vote_candidate_2, vote_candidate_3,
                voting_session_done, sched_busy};
    endfunction

    function automatic int pick(input logic [NB-1:0] m);
        for (int k = 0; k < NB; k++) begin
            int idx;
            idx = (exp_ptr + k) % NB;
            if (m[idx]) return idx;
        end
        return -1;
    endfunction

    // Scoreboard plus core tally: pops the expected code whenever a vote strobe is seen.
    always @(negedge clk) begin
        logic [1:0] obs_code;
        if (vote_candidate_1 || vote_candidate_2 || vote_candidate_3) begin
            obs_code = vote_candidate_1 ? 2'b01 : (vote_candidate_2 ? 2'b10 : 2'b11);
            check("vote_onehot", 32'(vote_candidate_1) + 32'(vote_candidate_2) + 32'(vote_candidate_3), 1);
            check("ready_vote_overlap", candidate_ready, 0);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $error("FAIL unexpected_vote: observed code %0d expected none", obs_code);
            end else begin
                check("vote_code", obs_code, exp_q.pop_front());
            end
            if (vote_candidate_1) core_c1++;
            if (vote_candidate_2) core_c2++;
            if (vote_candidate_3) core_c3++;
        end
        if (voting_session_done) core_done = 1'b1;
    end

    task automatic model_clear();
        exp_ptr = 0; exp_voters = 0;
        core_c1 = 0; core_c2 = 0; core_c3 = 0; core_done = 1'b0;
    endtask

    // Drives one full booth service starting with the DUT in ARB at this negedge.
    task automatic service(input logic [NB-1:0] mask, input logic [1:0] code,
                           input bit keep_req, input bit close_at_cast, output int g);
        g = pick(mask);
        booth_req = mask;
        tick(1);
        check("grant", booth_grant, 1 << g);
        check("state_wait", dbg_state, S_WAIT_VOTE);
        check("busy_wait", sched_busy, 1);
        if (!keep_req) booth_req = '0;
        booth_vote_valid = NB'($urandom_range(0, (1 << NB) - 1));
        booth_vote_valid[g] = 1'b1;
        booth_vote = (2*NB)'($urandom);
        booth_vote[2*g +: 2] = code;
        tick(1);
        booth_vote_valid = '0;
        if (code == VOTE_NONE) begin
            check("reject", booth_reject, 1 << g);
            check("no_ready_on_reject", candidate_ready, 0);
            check("voters_after_reject", voters_served, exp_voters);
            exp_ptr = (g + 1) % NB;
            return;
        end
        check("ready", candidate_ready, 1);
        check("no_reject", booth_reject, 0);
        exp_q.push_back(code);
        tick(1);
        check("cast_ready_low", candidate_ready, 0);
        check("state_cast", dbg_state, S_CAST);
        if (close_at_cast) close_req = 1'b1;
        tick(1);
        check("ack", booth_ack, 1 << g);
        check("settle_core_quiet", {candidate_ready, vote_candidate_1, vote_candidate_2, vote_candidate_3}, 0);
        check("voters_before_inc", voters_served, exp_voters);
        tick(1);
        exp_voters++;
        exp_ptr = (g + 1) % NB;
        check("voters", voters_served, exp_voters);
        check("ack_pulse", booth_ack, 0);
    endtask

    initial begin
        int g;
        int iter;
        rst = 1'b0; switch_on_evm = 1'b0; close_req = 1'b0;
        booth_req = '0; booth_vote_valid = '0; booth_vote = '0;
        tick(3);
        check("reset_outs", outs_vec(), 0);
        check("reset_state", dbg_state, S_IDLE);
        check("reset_voters", voters_served, 0);

        rst = 1'b1; switch_on_evm = 1'b1;
        tick(1);
        check("power_on_arb", dbg_state, S_ARB);
        check("power_on_idle_outs", outs_vec(), 0);

        // Single vote from booth 2, candidate 2.
        service(4'b0100, 2'b10, 1'b0, 1'b0, g);
        check("single_core_c2", core_c2, 1);
        check("single_voters", voters_served, 1);

        // Invalid code from booth 1, then booth 2 wins over booth 1.
        service(4'b0010, 2'b00, 1'b0, 1'b0, g);
        check("reject_state_arb", dbg_state, S_ARB);
        tick(1);
        check("reject_pulse_once", booth_reject, 0);
        service(4'b0110, 2'b01, 1'b0, 1'b0, g);
        check("after_reject_grant_b2", g, 2);

        // Fairness after a fresh power cycle.
        switch_on_evm = 1'b0;
        tick(1);
        check("poweroff_voters", voters_served, 0);
        model_clear();
        switch_on_evm = 1'b1;
        tick(1);
        for (int i = 0; i < 8; i++) begin
            service(4'hF, 2'b01, 1'b1, 1'b0, g);
        end
        check("fair_voters", voters_served, 8);
        check("fair_core_c1", core_c1, 8);

        // Close requested mid-service: vote completes, then close beats pending requests.
        service(4'hF, 2'b11, 1'b1, 1'b1, g);
        tick(1);
        check("close_done_pulse", voting_session_done, 1);
        check("close_no_grant", booth_grant, 0);
        tick(1);
        check("done_state", dbg_state, S_DONE);
        check("done_outs", outs_vec(), 0);
        check("done_voters", voters_served, 9);
        check("core_voting_done", core_done, 1);
        close_req = 1'b0; booth_req = '0;
        tick(3);
        check("done_holds", dbg_state, S_DONE);

        switch_on_evm = 1'b0;
        tick(1);
        check("off_state", dbg_state, S_IDLE);
        check("off_voters", voters_served, 0);
        check("off_outs", outs_vec(), 0);
        model_clear();
        switch_on_evm = 1'b1;
        tick(1);

        // Saturation: fill the counter with random booths and codes.
        iter = 0;
        while (exp_voters < (1 << CW) - 1 && iter < 400) begin
            service(NB'($urandom_range(1, (1 << NB) - 1)), 2'($urandom_range(0, 3)), 1'b0, 1'b0, g);
            iter++;
        end
        check("sat_voters", voters_served, (1 << CW) - 1);
        booth_req = 4'hF;
        tick(6);
        check("sat_no_grant", booth_grant, 0);
        check("sat_state_arb", dbg_state, S_ARB);
        booth_req = '0;

        // Synchronous reset while in READY.
        switch_on_evm = 1'b0;
        tick(1);
        model_clear();
        switch_on_evm = 1'b1;
        tick(1);
        booth_req = 4'b0001;
        tick(1);
        check("rst_mid_grant", booth_grant, 1);
        booth_req = '0;
        booth_vote_valid = 4'b0001; booth_vote = 8'b0000_0001;
        tick(1);
        booth_vote_valid = '0;
        check("rst_mid_ready", candidate_ready, 1);
        rst = 1'b0;
        tick(1);
        check("rst_mid_outs", outs_vec(), 0);
        check("rst_mid_state", dbg_state, S_IDLE);
        rst = 1'b1;
        tick(1);
        check("rst_release_arb", dbg_state, S_ARB);

        booth_req = 4'b0001;
        tick(1);
        check("wait_grant", booth_grant, 1);
        booth_req = '0;
`ifdef EVM_SCHED_TIMEOUT_EN
        begin
            int waited;
            waited = 0;
            while (booth_reject == '0 && waited < 200) begin
                tick(1);
                waited++;
            end
            check("timeout_cycles", waited, 64);
            check("timeout_reject", booth_reject, 1);
        end
`else
        begin
            int rej_seen;
            rej_seen = 0;
            repeat (1000) begin
                tick(1);
                if (booth_reject != '0) rej_seen++;
            end
            check("no_timeout_grant", booth_grant, 1);
            check("no_timeout_reject", rej_seen, 0);
        end
`endif

        check("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
